nbit_demux_router: RTL

NBIT_DEMUX_ROUTER -- requirements
Module: nbit_demux_router

---
 rtl/nbit_demux_pkg.sv | 12 +
 rtl/demux_out_slot.sv | 64 ++++++
 rtl/nbit_demux_router.sv | 58 +++++
 3 files changed

// File: rtl/nbit_demux_pkg.sv
// Shared constants and types for the two-channel demux router.
package nbit_demux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output slot: holds a routed word until its consumer takes it,
// and keeps a saturating count of words delivered.
//   state | meaning
//   EMPTY | no word held, x_valid low
//   FULL  | word held on x_data, x_valid high until x_ready
module demux_out_slot
  import nbit_demux_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [N-1:0]  load_data,
  input  logic          x_ready,
  output logic          x_valid,
  output logic [N-1:0]  x_data,
  output logic [CW-1:0] x_count,
  output logic          can_load
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  slot_state_e   state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [CW-1:0] count_q, count_d;
  logic          fire;

  assign fire     = (state_q == FULL) && x_ready;
  assign x_valid  = (state_q == FULL);
  assign x_data   = data_q;
  assign x_count  = count_q;
  // A slot being drained this cycle can take a new word without a bubble.
  assign can_load = (state_q == EMPTY) || x_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    if (load) begin
      state_d = FULL;
      data_d  = load_data;
    end else if (fire) begin
      state_d = EMPTY;
    end
    if (fire && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/nbit_demux_router.sv
// Routes each accepted input word to channel A or B according to sel.
// Top level only decodes sel, generates slot loads and muxes in_ready.
module nbit_demux_router
  import nbit_demux_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          sel,
  output logic          a_valid,
  output logic [N-1:0]  a_data,
  input  logic          a_ready,
  output logic          b_valid,
  output logic [N-1:0]  b_data,
  input  logic          b_ready,
  output logic [CW-1:0] a_count,
  output logic [CW-1:0] b_count
);

  logic a_can_load, b_can_load;
  logic in_fire, load_a, load_b;

  // in_ready is held low while reset is asserted so nothing is accepted.
  assign in_ready = rst_n && ((sel == SEL_B) ? b_can_load : a_can_load);
  assign in_fire  = in_valid && in_ready;
  assign load_a   = in_fire && (sel == SEL_A);
  assign load_b   = in_fire && (sel == SEL_B);

  demux_out_slot #(.N(N), .CW(CW)) u_slot_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_a),
    .load_data (in_data),
    .x_ready   (a_ready),
    .x_valid   (a_valid),
    .x_data    (a_data),
    .x_count   (a_count),
    .can_load  (a_can_load)
  );

  demux_out_slot #(.N(N), .CW(CW)) u_slot_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_b),
    .load_data (in_data),
    .x_ready   (b_ready),
    .x_valid   (b_valid),
    .x_data    (b_data),
    .x_count   (b_count),
    .can_load  (b_can_load)
  );

endmodule
